// File: rtl/decode_pkg.sv
// Shared opcode constants, instruction format enum and decoded-entry record for the decode stage.
// The strict encoding checks in decode_comb are enabled by defining DECODE_STRICT_CHECK_EN.
package decode_pkg;

    localparam int MAX_XLEN = 64;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_ILL = 3'd0,
        FMT_R   = 3'd1,
        FMT_I   = 3'd2,
        FMT_S   = 3'd3,
        FMT_B   = 3'd4,
        FMT_U   = 3'd5,
        FMT_J   = 3'd6
    } fmt_e;

    // pc and imm are sized for the widest datapath; narrower builds use the low bits.
    typedef struct packed {
        logic [MAX_XLEN-1:0] pc;
        logic [6:0]          opcode;
        logic [4:0]          rd;
        logic [2:0]          func3;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [6:0]          func7;
        fmt_e                fmt;
        logic [MAX_XLEN-1:0] imm;
        logic                rd_we;
        logic                rs1_used;
        logic                rs2_used;
        logic                illegal;
    } entry_t;

    function automatic logic [MAX_XLEN-1:0] sext32(input logic [31:0] v);
        return {{(MAX_XLEN-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake/bus bundle of the decode stage.
// master = environment driving fetch data and downstream ready; slave = the decode stage.
interface decode_stage_if #(
    parameter int XLEN = 32,
    parameter int PC_W = XLEN
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [4:0]      out_rd;
    logic [2:0]      out_func3;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [6:0]      out_func7;
    logic [2:0]      out_fmt;
    logic [XLEN-1:0] out_imm;
    logic            out_rd_we;
    logic            out_rs1_used;
    logic            out_rs2_used;
    logic            out_illegal;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_func3, out_rs1,
               out_rs2, out_func7, out_fmt, out_imm, out_rd_we, out_rs1_used,
               out_rs2_used, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_rd, out_func3, out_rs1,
               out_rs2, out_func7, out_fmt, out_imm, out_rd_we, out_rs1_used,
               out_rs2_used, out_illegal
    );
endinterface

// File: rtl/decode_comb.sv
// Purely combinational RV32I/RV64I instruction-to-entry decode.
// Defining DECODE_STRICT_CHECK_EN also flags bad encodings inside otherwise legal opcodes.
module decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = XLEN
) (
    input  logic [31:0]     instr,
    input  logic [PC_W-1:0] pc,
    output entry_t          entry
);

    localparam logic RV64 = (XLEN == 64);

    logic [6:0]  opcode_s;
    logic [2:0]  func3_s;
    logic [6:0]  func7_s;
    fmt_e        base_fmt_s;
    fmt_e        fmt_s;
    logic        bad_enc_s;
    logic        fence_sys_s;
    logic [31:0] imm32_s;

    assign opcode_s    = instr[6:0];
    assign func3_s     = instr[14:12];
    assign func7_s     = instr[31:25];
    assign fence_sys_s = (opcode_s == OPC_MISC_MEM) || (opcode_s == OPC_SYSTEM);

    // Opcode to format; the *W opcodes only exist on RV64.
    always_comb begin
        base_fmt_s = FMT_ILL;
        case (opcode_s)
            OPC_OP:        base_fmt_s = FMT_R;
            OPC_OP_32:     base_fmt_s = RV64 ? FMT_R : FMT_ILL;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM:
                           base_fmt_s = FMT_I;
            OPC_OP_IMM_32: base_fmt_s = RV64 ? FMT_I : FMT_ILL;
            OPC_STORE:     base_fmt_s = FMT_S;
            OPC_BRANCH:    base_fmt_s = FMT_B;
            OPC_LUI, OPC_AUIPC:
                           base_fmt_s = FMT_U;
            OPC_JAL:       base_fmt_s = FMT_J;
            default:       base_fmt_s = FMT_ILL;
        endcase
    end

`ifdef DECODE_STRICT_CHECK_EN
    // Encoding checks for func3/func7 values that no RV32I/RV64I instruction uses.
    always_comb begin
        bad_enc_s = 1'b0;
        if ((instr[1:0] != 2'b11) || (instr == 32'h0000_0000)) begin
            bad_enc_s = 1'b1;
        end else begin
            case (opcode_s)
                OPC_OP, OPC_OP_32:
                    bad_enc_s = (func7_s != 7'b0000000) && (func7_s != 7'b0100000);
                OPC_JALR:
                    bad_enc_s = (func3_s != 3'b000);
                OPC_LOAD:
                    case (func3_s)
                        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: bad_enc_s = 1'b0;
                        3'b011, 3'b110:                         bad_enc_s = !RV64;
                        default:                                bad_enc_s = 1'b1;
                    endcase
                OPC_STORE:
                    case (func3_s)
                        3'b000, 3'b001, 3'b010: bad_enc_s = 1'b0;
                        3'b011:                 bad_enc_s = !RV64;
                        default:                bad_enc_s = 1'b1;
                    endcase
                OPC_BRANCH:
                    bad_enc_s = (func3_s == 3'b010) || (func3_s == 3'b011);
                default:
                    bad_enc_s = 1'b0;
            endcase
        end
    end
`else
    assign bad_enc_s = 1'b0;
`endif

    assign fmt_s = bad_enc_s ? FMT_ILL : base_fmt_s;

    // Format-selected immediate, sign-extended from instr[31].
    always_comb begin
        imm32_s = 32'h0000_0000;
        case (fmt_s)
            FMT_I:   imm32_s = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm32_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm32_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                instr[11:8], 1'b0};
            FMT_U:   imm32_s = {instr[31:12], 12'h000};
            FMT_J:   imm32_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                instr[30:21], 1'b0};
            default: imm32_s = 32'h0000_0000;
        endcase
    end

    // Assemble the entry record including register-use flags.
    always_comb begin
        entry          = '0;
        entry.pc       = MAX_XLEN'(pc);
        entry.opcode   = opcode_s;
        entry.rd       = instr[11:7];
        entry.func3    = func3_s;
        entry.rs1      = instr[19:15];
        entry.rs2      = instr[24:20];
        entry.func7    = func7_s;
        entry.fmt      = fmt_s;
        entry.imm      = sext32(imm32_s);
        entry.rs1_used = (fmt_s inside {FMT_R, FMT_I, FMT_S, FMT_B}) && !fence_sys_s;
        entry.rs2_used = (fmt_s inside {FMT_R, FMT_S, FMT_B});
        entry.rd_we    = (fmt_s inside {FMT_R, FMT_I, FMT_U, FMT_J})
                         && (instr[11:7] != 5'd0)
                         && !(fence_sys_s && (func3_s == 3'b000));
        entry.illegal  = (fmt_s == FMT_ILL);
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decode_comb feeding an output register plus one skid entry,
// so in_ready is a flop and never combinationally depends on out_ready.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = XLEN
) (
    input  logic           clk,
    input  logic           rst_n,
    decode_stage_if.slave  bus
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    occ_e   state_r;
    occ_e   state_s;
    entry_t dec_s;
    entry_t out_r;
    entry_t skid_r;
    logic   out_valid_r;
    logic   in_ready_r;
    logic   accept_s;
    logic   retire_s;
    logic   load_out_in_s;
    logic   load_out_skid_s;
    logic   load_skid_s;
    logic   unused_s;

    decode_comb #(.XLEN(XLEN), .PC_W(PC_W)) u_decode_comb (
        .instr (bus.in_instr),
        .pc    (bus.in_pc),
        .entry (dec_s)
    );

    assign accept_s = bus.in_valid & in_ready_r;
    assign retire_s = out_valid_r & bus.out_ready;

    // Occupancy next-state and register load selects; flush empties the stage.
    always_comb begin
        state_s         = state_r;
        load_out_in_s   = 1'b0;
        load_out_skid_s = 1'b0;
        load_skid_s     = 1'b0;
        if (bus.flush) begin
            state_s = OCC_EMPTY;
        end else begin
            case (state_r)
                OCC_EMPTY: begin
                    if (accept_s) begin
                        state_s       = OCC_ONE;
                        load_out_in_s = 1'b1;
                    end else begin
                        state_s = OCC_EMPTY;
                    end
                end
                OCC_ONE: begin
                    if (accept_s && retire_s) begin
                        state_s       = OCC_ONE;
                        load_out_in_s = 1'b1;
                    end else if (accept_s) begin
                        state_s     = OCC_TWO;
                        load_skid_s = 1'b1;
                    end else if (retire_s) begin
                        state_s = OCC_EMPTY;
                    end else begin
                        state_s = OCC_ONE;
                    end
                end
                OCC_TWO: begin
                    if (retire_s) begin
                        state_s         = OCC_ONE;
                        load_out_skid_s = 1'b1;
                    end else begin
                        state_s = OCC_TWO;
                    end
                end
                default: state_s = OCC_EMPTY;
            endcase
        end
    end

    // Occupancy state plus handshake flags registered from the next occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= OCC_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_s;
            out_valid_r <= (state_s != OCC_EMPTY);
            in_ready_r  <= (state_s != OCC_TWO);
        end
    end

    // Output and skid data registers; the output register holds while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_r  <= '0;
            skid_r <= '0;
        end else begin
            if (load_out_in_s) begin
                out_r <= dec_s;
            end else if (load_out_skid_s) begin
                out_r <= skid_r;
            end
            if (load_skid_s) begin
                skid_r <= dec_s;
            end
        end
    end

    assign bus.in_ready     = in_ready_r;
    assign bus.out_valid    = out_valid_r;
    assign bus.out_pc       = out_r.pc[PC_W-1:0];
    assign bus.out_opcode   = out_r.opcode;
    assign bus.out_rd       = out_r.rd;
    assign bus.out_func3    = out_r.func3;
    assign bus.out_rs1      = out_r.rs1;
    assign bus.out_rs2      = out_r.rs2;
    assign bus.out_func7    = out_r.func7;
    assign bus.out_fmt      = out_r.fmt;
    assign bus.out_imm      = out_r.imm[XLEN-1:0];
    assign bus.out_rd_we    = out_r.rd_we;
    assign bus.out_rs1_used = out_r.rs1_used;
    assign bus.out_rs2_used = out_r.rs2_used;
    assign bus.out_illegal  = out_r.illegal;

    // Bits above PC_W/XLEN are deliberately dropped on narrow builds.
    assign unused_s = ^{out_r.pc, out_r.imm};

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: XLEN=32 and XLEN=64 instances driven in lockstep, checked against
// a queue-based occupancy model and an arithmetic decode model.
module tb_decode_stage;
    import decode_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    decode_stage_if #(.XLEN(32)) if32 ();
    decode_stage_if #(.XLEN(64)) if64 ();

    decode_stage #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
    decode_stage #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(if64));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } item_t;

    typedef struct {
        logic [2:0]  fmt;
        logic [63:0] imm;
        logic [3:0]  flags;   // {rd_we, rs1_used, rs2_used, illegal}
    } exp_t;

    localparam logic [6:0] OPS [14] = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h03, 7'h67, 7'h73,
                                        7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h2B};

    item_t q[$];

    function automatic exp_t model(input logic [31:0] w, input int xlen);
        exp_t e;
        logic [6:0] op;
        logic [2:0] f3;
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic fs;
        logic bad;
        op  = w[6:0];
        f3  = w[14:12];
        s   = 64'($signed(w));
        bad = 1'b0;
        case (op)
            7'h33:                             e.fmt = FMT_R;
            7'h3B:                             e.fmt = (xlen == 64) ? FMT_R : FMT_ILL;
            7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: e.fmt = FMT_I;
            7'h1B:                             e.fmt = (xlen == 64) ? FMT_I : FMT_ILL;
            7'h23:                             e.fmt = FMT_S;
            7'h63:                             e.fmt = FMT_B;
            7'h37, 7'h17:                      e.fmt = FMT_U;
            7'h6F:                             e.fmt = FMT_J;
            default:                           e.fmt = FMT_ILL;
        endcase
`ifdef DECODE_STRICT_CHECK_EN
        if (w == 32'd0 || w[1:0] != 2'b11) bad = 1'b1;
        if ((op == 7'h33 || op == 7'h3B) && !(w[31:25] == 7'h00 || w[31:25] == 7'h20)) bad = 1'b1;
        if (op == 7'h67 && f3 != 3'd0) bad = 1'b1;
        if (op == 7'h03 && (f3 == 3'd7 || ((f3 == 3'd3 || f3 == 3'd6) && xlen != 64))) bad = 1'b1;
        if (op == 7'h23 && (f3 > 3'd3 || (f3 == 3'd3 && xlen != 64))) bad = 1'b1;
        if (op == 7'h63 && (f3 == 3'd2 || f3 == 3'd3)) bad = 1'b1;
`endif
        if (bad) e.fmt = FMT_ILL;
        case (e.fmt)
            FMT_I: begin hi = s >>> 20; e.imm = hi; end
            FMT_S: begin hi = s >>> 25; e.imm = (hi << 5) | 64'(w[11:7]); end
            FMT_B: begin hi = s >>> 31;
                e.imm = (hi << 12) | (64'(w[7]) << 11) | (64'(w[30:25]) << 5) | (64'(w[11:8]) << 1); end
            FMT_U: begin hi = s >>> 12; e.imm = hi << 12; end
            FMT_J: begin hi = s >>> 31;
                e.imm = (hi << 20) | (64'(w[19:12]) << 12) | (64'(w[20]) << 11) | (64'(w[30:21]) << 1); end
            default: e.imm = 64'd0;
        endcase
        fs = (op == 7'h0F) || (op == 7'h73);
        e.flags[3] = (e.fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) && (w[11:7] != 5'd0) && !(fs && f3 == 3'd0);
        e.flags[2] = (e.fmt inside {FMT_R, FMT_I, FMT_S, FMT_B}) && !fs;
        e.flags[1] = (e.fmt inside {FMT_R, FMT_S, FMT_B});
        e.flags[0] = (e.fmt == FMT_ILL);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        exp_t e32;
        exp_t e64;
        logic ev;
        ev = (q.size() > 0);
        chk("valid32", 64'(if32.out_valid), 64'(ev));
        chk("valid64", 64'(if64.out_valid), 64'(ev));
        chk("ready32", 64'(if32.in_ready), 64'(q.size() < 2));
        chk("ready64", 64'(if64.in_ready), 64'(q.size() < 2));
        if (ev) begin
            e32 = model(q[0].instr, 32);
            e64 = model(q[0].instr, 64);
            chk("pc32", 64'(if32.out_pc), 64'(q[0].pc[31:0]));
            chk("pc64", if64.out_pc, q[0].pc);
            chk("fields32", 64'({if32.out_func7, if32.out_rs2, if32.out_rs1, if32.out_func3,
                                 if32.out_rd, if32.out_opcode}), 64'(q[0].instr));
            chk("fields64", 64'({if64.out_func7, if64.out_rs2, if64.out_rs1, if64.out_func3,
                                 if64.out_rd, if64.out_opcode}), 64'(q[0].instr));
            chk("fmt32", 64'(if32.out_fmt), 64'(e32.fmt));
            chk("fmt64", 64'(if64.out_fmt), 64'(e64.fmt));
            chk("imm32", 64'(if32.out_imm), 64'(e32.imm[31:0]));
            chk("imm64", if64.out_imm, e64.imm);
            chk("flags32", 64'({if32.out_rd_we, if32.out_rs1_used, if32.out_rs2_used, if32.out_illegal}),
                64'(e32.flags));
            chk("flags64", 64'({if64.out_rd_we, if64.out_rs1_used, if64.out_rs2_used, if64.out_illegal}),
                64'(e64.flags));
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_v32"}, 64'(if32.out_valid), 64'd0);
        chk({tag, "_v64"}, 64'(if64.out_valid), 64'd0);
        chk({tag, "_r32"}, 64'(if32.in_ready), 64'd1);
        chk({tag, "_r64"}, 64'(if64.in_ready), 64'd1);
        chk({tag, "_d32"}, 64'({if32.out_pc, if32.out_opcode, if32.out_rd, if32.out_func3, if32.out_rs1,
                               if32.out_rs2, if32.out_func7, if32.out_fmt, if32.out_rd_we,
                               if32.out_rs1_used, if32.out_rs2_used, if32.out_illegal}), 64'd0);
        chk({tag, "_i32"}, 64'(if32.out_imm), 64'd0);
        chk({tag, "_p64"}, if64.out_pc, 64'd0);
        chk({tag, "_d64"}, 64'({if64.out_opcode, if64.out_rd, if64.out_func3, if64.out_rs1,
                               if64.out_rs2, if64.out_func7, if64.out_fmt, if64.out_rd_we,
                               if64.out_rs1_used, if64.out_rs2_used, if64.out_illegal}), 64'd0);
        chk({tag, "_i64"}, if64.out_imm, 64'd0);
    endtask

    // One clock: drive, advance the reference queue at the edge, check at the falling edge.
    task automatic cycle(input logic v, input logic [31:0] w, input logic [63:0] pc,
                         input logic rdy, input logic fl, input logic rst);
        logic acc;
        logic ret;
        rst_n         = rst;
        if32.in_valid = v;  if64.in_valid = v;
        if32.in_instr = w;  if64.in_instr = w;
        if32.in_pc    = pc[31:0];
        if64.in_pc    = pc;
        if32.out_ready = rdy; if64.out_ready = rdy;
        if32.flush    = fl; if64.flush    = fl;
        acc = v && (q.size() < 2);
        ret = rdy && (q.size() > 0);
        @(posedge clk);
        if (!rst || fl) begin
            q.delete();
        end else begin
            if (ret) void'(q.pop_front());
            if (acc) q.push_back('{w, pc});
        end
        @(negedge clk);
        check_all();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int sel;
        w   = $urandom;
        sel = $urandom_range(0, 15);
        if (sel < 14) w[6:0] = OPS[sel];
        if (sel == 14) w = 32'd0;
        if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return w;
    endfunction

    function automatic logic [63:0] rand_pc();
        return {$urandom, $urandom};
    endfunction

    initial begin
        // reset
        cycle(1'b1, 32'h0050_0093, 64'h10, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        check_zero("reset");

        // addi x1,x0,5
        cycle(1'b1, 32'h0050_0093, 64'h1000, 1'b0, 1'b0, 1'b1);
        chk("addi_imm", 64'(if32.out_imm), 64'h5);
        chk("addi_fmt", 64'(if32.out_fmt), 64'(FMT_I));
        chk("addi_rd_rs1", 64'({if32.out_rd, if32.out_rs1}), 64'({5'd1, 5'd0}));
        chk("addi_we_rs2", 64'({if32.out_rd_we, if32.out_rs2_used}), 64'(2'b10));
        cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b1);

        // beq x0,x0,-4
        cycle(1'b1, 32'hFE00_0EE3, 64'h1004, 1'b0, 1'b0, 1'b1);
        chk("beq_fmt", 64'(if32.out_fmt), 64'(FMT_B));
        chk("beq_imm", 64'(if32.out_imm), 64'hFFFF_FFFC);
        chk("beq_flags", 64'({if32.out_rd_we, if32.out_rs1_used, if32.out_rs2_used}), 64'(3'b011));
        // lui x5 variants and jal on the RV64 instance
        cycle(1'b1, 32'h1234_52B7, 64'h1008, 1'b1, 1'b0, 1'b1);
        chk("lui_imm64", if64.out_imm, 64'h0000_0000_1234_5000);
        cycle(1'b1, 32'h8000_02B7, 64'h100C, 1'b1, 1'b0, 1'b1);
        chk("lui_neg64", if64.out_imm, 64'hFFFF_FFFF_8000_0000);
        chk("lui_neg32", 64'(if32.out_imm), 64'h8000_0000);
        cycle(1'b1, 32'h0080_00EF, 64'h1010, 1'b1, 1'b0, 1'b1);
        chk("jal_fmt", 64'(if64.out_fmt), 64'(FMT_J));
        chk("jal_imm", if64.out_imm, 64'h8);
        cycle(1'b1, 32'h0220_8033, 64'h1014, 1'b1, 1'b0, 1'b1);
`ifdef DECODE_STRICT_CHECK_EN
        chk("mulenc_ill", 64'({if32.out_illegal, if32.out_fmt}), 64'({1'b1, FMT_ILL}));
`else
        chk("mulenc_r", 64'({if32.out_illegal, if32.out_fmt}), 64'({1'b0, FMT_R}));
`endif
        cycle(1'b1, 32'h0000_0000, 64'h1018, 1'b1, 1'b0, 1'b1);
        chk("zero_ill", 64'({if64.out_illegal, if64.out_fmt}), 64'({1'b1, FMT_ILL}));
        cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b1);

        // backpressure: three offered, two held, third refused
        cycle(1'b1, 32'h0010_0113, 64'h2000, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h0020_0193, 64'h2004, 1'b0, 1'b0, 1'b1);
        chk("full_ready", 64'(if32.in_ready), 64'd0);
        cycle(1'b1, 32'h0030_0213, 64'h2008, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h0030_0213, 64'h2008, 1'b0, 1'b0, 1'b1);
        chk("stall_pc", if64.out_pc, 64'h2000);
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b1);

        // flush while full with an incoming word
        cycle(1'b1, 32'h0040_0293, 64'h3000, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h0050_0313, 64'h3004, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h0060_0393, 64'h3008, 1'b0, 1'b1, 1'b1);
        chk("flush_valid", 64'(if64.out_valid), 64'd0);
        chk("flush_ready", 64'(if64.in_ready), 64'd1);
        cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 2) != 0), rand_instr(), rand_pc(),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0), 1'b1);
        end

        // reset mid-stream
        cycle(1'b1, 32'h0070_0413, 64'h4000, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h0080_0493, 64'h4004, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h0090_0513, 64'h4008, 1'b1, 1'b1, 1'b0);
        check_zero("midrst");
        cycle(1'b1, 32'h00A0_0593, 64'h4010, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised RV32I/RV64I instruction decode stage between the fetch buffer and the register-read/execute stage.
- Generalises the team's combinational field and immediate decoder in five ways:
  - XLEN-wide sign-extended immediates.
  - U-type support.
  - A single format-selected immediate output.
  - Register-use flags.
  - A valid/ready handshake with a 2-entry skid buffer, so backpressure does not create a combinational ready path to fetch.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64. Immediates and PC are XLEN bits.
- PC_W, XLEN, width of the carried program counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  kill all held entries (branch redirect/trap).
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept; registered.
- in_instr  in  32  raw instruction word.
- in_pc  in  PC_W  PC of in_instr.
- out_valid  out  1  decoded entry available.
- out_ready  in  1  downstream accepts.
- out_pc  out  PC_W  PC of the decoded entry.
- out_opcode  out  7  instr[6:0].
- out_rd  out  5  instr[11:7].
- out_func3  out  3  instr[14:12].
- out_rs1  out  5  instr[19:15].
- out_rs2  out  5  instr[24:20].
- out_func7  out  7  instr[31:25].
- out_fmt  out  3  format enum: R, I, S, B, U, J, ILL.
- out_imm  out  XLEN  immediate for out_fmt, sign-extended to XLEN; 0 for R and ILL.
- out_rd_we  out  1  instruction writes rd, and rd != 0.
- out_rs1_used  out  1  rs1 is read.
- out_rs2_used  out  1  rs2 is read.
- out_illegal  out  1  unsupported opcode or encoding.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - out_valid=0, in_ready=1, skid empty.
  - All data outputs = 0; out_fmt = ILL encoding 0.
  - Takes priority over flush and over a handshake in the same cycle.
- Decode is combinational on the incoming word. Results are captured into the output register or the skid register, never re-decoded downstream.
- Latency: an instruction accepted at edge N appears with out_valid=1 after edge N (visible in cycle N+1) when the stage is empty.
- Accept = in_valid & in_ready. Retire = out_valid & out_ready.
- Storage is an output register (OUT) plus a skid register (SKID); occupancy is 0, 1 or 2 entries.
- in_ready = (occupancy < 2), registered from next-state occupancy. Worst-case lost cycle occurs only at full.
- State transitions (occupancy):
  - EMPTY: accept -> ONE (entry loads OUT).
  - ONE: accept only -> TWO if not retiring (entry loads SKID). Accept & retire -> ONE (new entry loads OUT). Retire only -> EMPTY.
  - TWO: retire -> ONE (SKID moves to OUT). in_ready=0, so no accept.
- Ordering is strict FIFO; no entry is duplicated or dropped.
- flush=1:
  - Occupancy -> 0 and out_valid=0 next cycle; in_ready=1 next cycle.
  - An accept in the same cycle is discarded.
  - Output data registers may hold stale values; checkers must qualify them with out_valid.
- out_valid=1 and data must hold stable while out_ready=0.
- Opcode map:
  - 0110011 / 0111011* -> R.
  - 0010011 / 0011011* / 0000011 / 1100111 / 1110011 / 0001111 -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0110111 / 0010111 -> U.
  - 1101111 -> J.
  - Anything else -> ILL.
  - Opcodes marked * are legal only when XLEN=64; otherwise ILL.
- Immediates (sign bit is instr[31], replicated to XLEN):
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}, sign-extended for XLEN=64.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Register-use flags:
  - rs1_used for R/I/S/B, except the I opcodes 0001111 and 1110011 (those report 0).
  - rs2_used for R/S/B.
  - rd_we for R/I/U/J where rd != 0, excluding 0001111 and 1110011 with func3=0.

Optional Feature:
- DECODE_STRICT_CHECK_EN.
- When defined, out_illegal and fmt=ILL also fire for invalid encodings within legal opcodes:
  - func7 not in {0000000, 0100000} for R-type.
  - func3 != 000 for JALR.
  - Undefined LOAD/STORE/BRANCH func3 values.
  - instr[1:0] != 11.
  - instr == 0.
- Without it, only unknown opcodes are illegal.

Decomposition:
- Package decode_pkg holds:
  - The opcode constants.
  - The fmt_e enum (3 bits, ILL=0).
  - The decoded-entry struct (pc, fields, fmt, imm, flags).
- One sub-module, decode_comb: purely combinational instruction-to-entry decode, parametrised by XLEN.
- decode_stage instantiates decode_comb and implements the OUT/SKID handshake logic.

Test Plan:
- XLEN=32: accept 0x00500093 (addi x1,x0,5) -> next cycle out_valid=1, fmt=I, rd=1, rs1=0, imm=0x00000005, rd_we=1, rs2_used=0.
- 0xFE000EE3 (beq x0,x0,-4) -> fmt=B, imm=0xFFFFFFFC, rd_we=0, rs1_used=rs2_used=1.
- XLEN=64:
  - 0x123452B7 (lui x5) -> imm=0x0000000012345000.
  - 0x800002B7 -> imm=0xFFFFFFFF80000000.
  - 0x008000EF (jal x1,8) -> fmt=J, imm=8.
- Backpressure:
  - Hold out_ready=0 and stream 3 instructions -> two accepted, in_ready=0 on the third.
  - Release out_ready -> outputs emerge in order, none lost, data stable while stalled.
- Flush with occupancy=2 and in_valid=1 -> next cycle out_valid=0, in_ready=1, the incoming word is discarded.
- Reset mid-stream: rst_n=0 for 1 cycle -> all outputs 0, out_valid=0.
- With DECODE_STRICT_CHECK_EN:
  - 0x00000000 -> out_illegal=1, fmt=ILL.
  - 0x02208033 (func7=0000001) -> illegal.
- Without DECODE_STRICT_CHECK_EN: 0x02208033 -> fmt=R, not illegal.
